pid_plant_model: RTL and testbench



---
 rtl/pid_plant_model.sv | 124 ++++++++++++
 tb/tb_pid_plant_model.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/pid_plant_model.sv
// rtl/pid_plant_model.sv - discrete first-order plant with transport delay and settle flag
// Feedback approaches the delayed control value as y += (u - y) >>> SHIFT once per sample.
module pid_plant_model #(
  parameter int SAMPLE_DIV = 4,
  parameter int SHIFT      = 2,
  parameter int DELAY      = 0,
  parameter int TOL        = 1,
  parameter int SETTLE_N   = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic [7:0] control_signal,
  output logic [7:0] feedback,
  output logic       sample_tick,
  output logic       settled
);

  localparam int PW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;

  logic [PW-1:0]      presc_q, presc_d;
  logic [15:0]        y_q, y_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [7:0]         feedback_q, feedback_d;
  logic               sample_tick_q, sample_tick_d;
  logic               settled_q, settled_d;
  logic               sample_edge;
  logic [7:0]         u_eff;
  logic signed [16:0] diff;
  logic signed [16:0] step;
  logic signed [17:0] sum;
  logic [8:0]         abs_err;

  assign sample_edge = enable && (presc_q == PW'(SAMPLE_DIV - 1));

  generate
    if (DELAY == 0) begin : g_no_delay
      assign u_eff = control_signal;
    end else begin : g_delay
      logic [7:0] dl_q [DELAY];
      logic [7:0] dl_d [DELAY];

      always_comb begin
        for (int i = 0; i < DELAY; i++) dl_d[i] = dl_q[i];
        if (sample_edge) begin
          dl_d[0] = control_signal;
          for (int i = 1; i < DELAY; i++) dl_d[i] = dl_q[i-1];
        end
      end

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          for (int i = 0; i < DELAY; i++) dl_q[i] <= 8'h00;
        end else begin
          for (int i = 0; i < DELAY; i++) dl_q[i] <= dl_d[i];
        end
      end

      // Oldest entry is read before this edge's shift lands.
      assign u_eff = dl_q[DELAY-1];
    end
  endgenerate

  always_comb begin
    diff = $signed({1'b0, u_eff, 8'h00}) - $signed({1'b0, y_q});
    step = diff >>> SHIFT;
    sum  = $signed({2'b00, y_q}) + $signed({step[16], step});

    presc_d       = presc_q;
    y_d           = y_q;
    cnt_d         = cnt_q;
    feedback_d    = feedback_q;
    settled_d     = settled_q;
    sample_tick_d = 1'b0;
    abs_err       = 9'd0;

    if (enable) begin
      presc_d = presc_q + PW'(1);
    end
    if (sample_edge) begin
      presc_d       = '0;
      sample_tick_d = 1'b1;
      if (sum < 0) begin
        y_d = 16'h0000;
      end else if (sum > 18'sd65535) begin
        y_d = 16'hFFFF;
      end else begin
        y_d = sum[15:0];
      end
      feedback_d = y_d[15:8];
      abs_err = (control_signal >= feedback_d) ? {1'b0, control_signal} - {1'b0, feedback_d}
                                               : {1'b0, feedback_d} - {1'b0, control_signal};
      if (abs_err <= 9'(TOL)) begin
        cnt_d = (cnt_q == 4'(SETTLE_N)) ? cnt_q : cnt_q + 4'd1;
      end else begin
        cnt_d = 4'd0;
      end
      settled_d = (cnt_d == 4'(SETTLE_N));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc_q       <= '0;
      y_q           <= 16'h0000;
      cnt_q         <= 4'd0;
      feedback_q    <= 8'h00;
      sample_tick_q <= 1'b0;
      settled_q     <= 1'b0;
    end else begin
      presc_q       <= presc_d;
      y_q           <= y_d;
      cnt_q         <= cnt_d;
      feedback_q    <= feedback_d;
      sample_tick_q <= sample_tick_d;
      settled_q     <= settled_d;
    end
  end

  assign feedback    = feedback_q;
  assign sample_tick = sample_tick_q;
  assign settled     = settled_q;

endmodule

// File: tb/tb_pid_plant_model.sv
// tb/tb_pid_plant_model.sv - self-checking bench for pid_plant_model
// Three plant configurations run side by side against an arithmetic reference model.
module tb_pid_plant_model;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable;
  logic [7:0] ctrl;
  logic [7:0] ctrl_c;
  logic [7:0] fb   [3];
  logic       tick [3];
  logic       setl [3];

  int checks = 0;
  int errors = 0;

  localparam int DIV [3] = '{4, 4, 1};
  localparam int SH  [3] = '{2, 2, 1};
  localparam int DLY [3] = '{0, 2, 0};
  localparam int M_TOL = 1;
  localparam int M_N   = 4;

  always #5 clk = ~clk;

  pid_plant_model #(.SAMPLE_DIV(4), .SHIFT(2), .DELAY(0), .TOL(1), .SETTLE_N(4)) u_a (
    .clk(clk), .rst_n(rst_n), .enable(enable), .control_signal(ctrl),
    .feedback(fb[0]), .sample_tick(tick[0]), .settled(setl[0]));

  pid_plant_model #(.SAMPLE_DIV(4), .SHIFT(2), .DELAY(2), .TOL(1), .SETTLE_N(4)) u_b (
    .clk(clk), .rst_n(rst_n), .enable(enable), .control_signal(ctrl),
    .feedback(fb[1]), .sample_tick(tick[1]), .settled(setl[1]));

  pid_plant_model #(.SAMPLE_DIV(1), .SHIFT(1), .DELAY(0), .TOL(1), .SETTLE_N(4)) u_c (
    .clk(clk), .rst_n(rst_n), .enable(enable), .control_signal(ctrl_c),
    .feedback(fb[2]), .sample_tick(tick[2]), .settled(setl[2]));

  // Reference state per instance, in plain integers.
  int mp [3], my [3], mcnt [3], mfb [3], mtick [3], mset [3];
  int mdl [3][8];

  initial begin
    for (int i = 0; i < 3; i++) begin
      mp[i] = 0; my[i] = 0; mcnt[i] = 0; mfb[i] = 0; mtick[i] = 0; mset[i] = 0;
      for (int k = 0; k < 8; k++) mdl[i][k] = 0;
    end
  end

  function automatic int floor_div(input int n, input int d);
    if (n >= 0) return n / d;
    return -((-n + d - 1) / d);
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      int c, u, ad;
      c = (i == 2) ? int'(ctrl_c) : int'(ctrl);
      if (!rst_n) begin
        mp[i] = 0; my[i] = 0; mcnt[i] = 0; mfb[i] = 0; mtick[i] = 0; mset[i] = 0;
        for (int k = 0; k < 8; k++) mdl[i][k] = 0;
      end else if (!enable) begin
        mtick[i] = 0;
      end else if (mp[i] == DIV[i] - 1) begin
        u = (DLY[i] == 0) ? c : mdl[i][DLY[i]-1];
        for (int k = 7; k > 0; k--) mdl[i][k] = mdl[i][k-1];
        mdl[i][0] = c;
        my[i] = my[i] + floor_div(u * 256 - my[i], 1 << SH[i]);
        if (my[i] < 0) my[i] = 0;
        if (my[i] > 65535) my[i] = 65535;
        mfb[i] = my[i] / 256;
        ad = (c > mfb[i]) ? c - mfb[i] : mfb[i] - c;
        mcnt[i] = (ad <= M_TOL) ? ((mcnt[i] + 1 > M_N) ? M_N : mcnt[i] + 1) : 0;
        mset[i] = (mcnt[i] == M_N) ? 1 : 0;
        mtick[i] = 1;
        mp[i] = 0;
      end else begin
        mp[i] = mp[i] + 1;
        mtick[i] = 0;
      end
    end
  end

  task automatic check_val(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check_val($sformatf("fb%0d", i), int'(fb[i]), mfb[i]);
      check_val($sformatf("tick%0d", i), int'(tick[i]), mtick[i]);
      check_val($sformatf("settled%0d", i), int'(setl[i]), mset[i]);
    end
  endtask

  task automatic wait_tick_a();
    int n;
    n = 0;
    do begin
      cyc();
      n++;
    end while (tick[0] !== 1'b1 && n < 20);
    if (tick[0] !== 1'b1) check_val("tick_a_timeout", 0, 1);
  endtask

  int qa [$], qb [$], qc [$], ta [$];
  int maxa, held;

  initial begin
    rst_n = 1'b0; enable = 1'b1; ctrl = 8'd200; ctrl_c = 8'd255;
    cyc(); cyc();
    check_val("rst_fb", int'(fb[0]), 0);
    check_val("rst_tick", int'(tick[0]), 0);
    check_val("rst_settled", int'(setl[0]), 0);
    rst_n = 1'b1;

    for (int n = 1; n <= 14; n++) begin
      cyc();
      if (tick[0]) begin qa.push_back(int'(fb[0])); ta.push_back(n); end
      if (tick[1]) qb.push_back(int'(fb[1]));
      if (tick[2]) qc.push_back(int'(fb[2]));
    end
    check_val("a_ticks", qa.size(), 3);
    check_val("b_ticks", qb.size(), 3);
    check_val("c_ticks", qc.size(), 14);
    if (qa.size() >= 3) begin
      check_val("a_t1", qa[0], 50);
      check_val("a_t2", qa[1], 87);
      check_val("a_t3", qa[2], 115);
      check_val("a_period1", ta[1] - ta[0], 4);
      check_val("a_period2", ta[2] - ta[1], 4);
    end
    if (qb.size() >= 3) begin
      check_val("b_t1", qb[0], 0);
      check_val("b_t2", qb[1], 0);
      check_val("b_t3", qb[2], 50);
    end
    if (qc.size() >= 3) begin
      check_val("c_t1", qc[0], 127);
      check_val("c_t2", qc[1], 191);
      check_val("c_t3", qc[2], 223);
    end

    // Freeze mid-ramp: outputs hold and no tick appears.
    cyc();
    enable = 1'b0;
    held = int'(fb[0]);
    for (int n = 0; n < 10; n++) begin
      cyc();
      check_val("frz_tick", int'(tick[0]), 0);
      check_val("frz_fb", int'(fb[0]), held);
    end
    enable = 1'b1;

    maxa = 0;
    for (int n = 0; n < 40; n++) begin
      wait_tick_a();
      if (int'(fb[0]) > maxa) maxa = int'(fb[0]);
    end
    check_val("a_max", maxa, 199);
    check_val("a_conv", int'(fb[0]), 199);
    check_val("a_settled", int'(setl[0]), 1);
    check_val("c_conv", int'(fb[2]), 254);
    check_val("c_settled", int'(setl[2]), 1);

    ctrl = 8'd0;
    wait_tick_a();
    check_val("a_unsettle", int'(setl[0]), 0);
    for (int n = 0; n < 40; n++) wait_tick_a();
    check_val("a_zero", int'(fb[0]), 0);

    // Mid-ramp reset with a populated delay line.
    ctrl = 8'd200;
    for (int n = 0; n < 10; n++) cyc();
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    check_val("mrst_fb_b", int'(fb[1]), 0);
    check_val("mrst_tick_b", int'(tick[1]), 0);
    check_val("mrst_set_b", int'(setl[1]), 0);

    for (int n = 0; n < 3000; n++) begin
      cyc();
      rst_n  = ($urandom_range(0, 199) != 0);
      enable = ($urandom_range(0, 9) < 8);
      if ($urandom_range(0, 29) == 0) ctrl = 8'($urandom);
      if ($urandom_range(0, 19) == 0) ctrl_c = 8'($urandom);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
